// File: rtl/lsu.sv
// Load/store unit for an RV32I core.
// Accepts one memory operation at a time from the execute stage. It runs a
// single request/grant/response handshake with data memory and returns
// formatted load data together with a one-cycle completion pulse.
// A misaligned access or an illegal funct3 completes at once with a fault
// and issues no memory request.
module lsu #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 is_store_i,
    input  logic [2:0]           funct3_i,
    input  logic [DataWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 fault_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [DataWidth-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [DataWidth-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [DataWidth-1:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    state_e               state_r;
    state_e               state_next_s;
    logic                 accept_s;
    logic                 legal_s;
    logic                 is_store_r;
    logic [2:0]           funct3_r;
    logic [DataWidth-1:0] addr_r;
    logic [3:0]           be_r;
    logic [DataWidth-1:0] sdata_r;
    logic [DataWidth-1:0] rdata_r;

    // Width/sign code legality and natural alignment check for one request.
    function automatic logic req_legal(input logic       is_store,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (addr_lo[0] == 1'b0);
            3'd2:    ok = (addr_lo == 2'b00);
            3'd4:    ok = !is_store;
            3'd5:    ok = !is_store && (addr_lo[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte-lane enables. funct3[1:0] encodes the size for signed and unsigned loads alike.
    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data into every lane so that the byte enables alone pick the target.
    function automatic logic [DataWidth-1:0] store_data(input logic [2:0]           funct3,
                                                        input logic [DataWidth-1:0] wdata);
        logic [DataWidth-1:0] d;
        d = wdata;
        case (funct3[1:0])
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Select the addressed lane of the raw word, then sign- or zero-extend it.
    function automatic logic [DataWidth-1:0] load_format(input logic [2:0]           funct3,
                                                         input logic [1:0]           addr_lo,
                                                         input logic [DataWidth-1:0] raw);
        logic [7:0]           b;
        logic [15:0]          h;
        logic [DataWidth-1:0] r;
        b = raw[{addr_lo, 3'b000} +: 8];
        h = addr_lo[1] ? raw[31:16] : raw[15:0];
        r = raw;
        case (funct3)
            3'd0:    r = {{24{b[7]}}, b};
            3'd1:    r = {{16{h[15]}}, h};
            3'd4:    r = {24'h000000, b};
            3'd5:    r = {16'h0000, h};
            default: r = raw;
        endcase
        return r;
    endfunction

    assign legal_s  = req_legal(is_store_i, funct3_i, addr_i[1:0]);
    assign accept_s = (state_r == ST_IDLE) && valid_i && legal_s;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic for the memory handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i) begin
                    if (legal_s) begin
                        state_next_s = ST_REQ;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    if (is_store_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            ST_ERR:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Capture request fields on acceptance; they stay frozen while the unit is busy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_store_r <= 1'b0;
            funct3_r   <= 3'd0;
            addr_r     <= '0;
            be_r       <= 4'b0000;
            sdata_r    <= '0;
        end else if (accept_s) begin
            is_store_r <= is_store_i;
            funct3_r   <= funct3_i;
            addr_r     <= addr_i;
            be_r       <= byte_enable(funct3_i, addr_i[1:0]);
            sdata_r    <= store_data(funct3_i, wdata_i);
        end else begin
            is_store_r <= is_store_r;
            funct3_r   <= funct3_r;
            addr_r     <= addr_r;
            be_r       <= be_r;
            sdata_r    <= sdata_r;
        end
    end

    // Load result register; updated only by a response that arrives while waiting for one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_r <= '0;
        end else if ((state_r == ST_WAIT) && mem_rvalid_i) begin
            rdata_r <= load_format(funct3_r, addr_r[1:0], mem_rdata_i);
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Output decode from the state register; memory signals are zero outside REQ.
    always_comb begin
        ready_o     = 1'b0;
        done_o      = 1'b0;
        fault_o     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        case (state_r)
            ST_IDLE: ready_o = 1'b1;
            ST_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = is_store_r;
                mem_addr_o  = {addr_r[DataWidth-1:2], 2'b00};
                mem_be_o    = be_r;
                mem_wdata_o = sdata_r;
            end
            ST_WAIT: ready_o = 1'b0;
            ST_DONE: done_o  = 1'b1;
            ST_ERR: begin
                done_o  = 1'b1;
                fault_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    assign rdata_o = rdata_r;

endmodule
